// File: rtl/sb_io_if.sv
// sb_io_if: core-side signals of the single-pin I/O cell.
interface sb_io_if;
  logic clock_enable;
  logic latch_input_value;
  logic output_enable;
  logic d_out_0;
  logic d_out_1;
  logic d_in_0;
  logic d_in_1;
  modport master (
    output clock_enable, latch_input_value, output_enable, d_out_0, d_out_1,
    input  d_in_0, d_in_1
  );
  modport slave (
    input  clock_enable, latch_input_value, output_enable, d_out_0, d_out_1,
    output d_in_0, d_in_1
  );
endinterface

// File: rtl/sb_io.sv
// sb_io: iCE40 SB_IO-style bidirectional pad cell with SDR/DDR/inverted output,
// registered or combinational tristate, latched/registered input and weak pull-up.
module sb_io #(
  parameter logic [5:0] PIN_TYPE = 6'b000000,
  parameter logic       PULLUP   = 1'b0
) (
  input  logic    clk,
  input  logic    reset,
  inout  wire     package_pin,
  sb_io_if.slave  io
);
  logic dout0_q, dout0_d, dout1_q, dout1_d, oe_q, oe_d;
  logic din0_q, din0_d, din1_q, din1_d, din_lat;
  logic hold0, dout, drv;
  // Input mode 10 freezes the registered input while the latch control is high.
  assign hold0 = (PIN_TYPE[1:0] == 2'b10) && io.latch_input_value;
  always_comb begin
    dout0_d = io.clock_enable ? io.d_out_0 : dout0_q;
    oe_d    = io.clock_enable ? io.output_enable : oe_q;
    din0_d  = (io.clock_enable && !hold0) ? package_pin : din0_q;
    dout1_d = io.clock_enable ? io.d_out_1 : dout1_q;
    din1_d  = io.clock_enable ? package_pin : din1_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dout0_q <= 1'b0;
      oe_q    <= 1'b0;
      din0_q  <= 1'b0;
    end else begin
      dout0_q <= dout0_d;
      oe_q    <= oe_d;
      din0_q  <= din0_d;
    end
  always_ff @(negedge clk or negedge reset)
    if (!reset) begin
      dout1_q <= 1'b0;
      din1_q  <= 1'b0;
    end else begin
      dout1_q <= dout1_d;
      din1_q  <= din1_d;
    end
  always_latch
    if (!reset) din_lat = 1'b0;
    else if (!io.latch_input_value) din_lat = package_pin;
  assign dout = (PIN_TYPE[3:2] == 2'b10) ? io.d_out_0 :
                (PIN_TYPE[3:2] == 2'b01) ? dout0_q :
                (PIN_TYPE[3:2] == 2'b11) ? ~dout0_q :
                (clk ? dout0_q : dout1_q);
  assign drv = (PIN_TYPE[5:4] == 2'b01) ? 1'b1 :
               (PIN_TYPE[5:4] == 2'b10) ? io.output_enable :
               (PIN_TYPE[5:4] == 2'b11) ? oe_q : 1'b0;
  assign package_pin = drv ? dout : 1'bz;
  generate
    if (PULLUP) begin : g_pu
      pullup u_pu (package_pin);
    end
  endgenerate
  assign io.d_in_0 = (PIN_TYPE[1:0] == 2'b01) ? package_pin :
                     (PIN_TYPE[1:0] == 2'b11) ? din_lat : din0_q;
  assign io.d_in_1 = din1_q;
endmodule

// File: tb/tb_sb_io.sv
// tb_sb_io: directed scoreboard bench over five PIN_TYPE configurations of sb_io.
module tb_sb_io;
  logic clk, reset;
  logic ea_en, ea_v, ee_v;
  wire  pin_a, pin_b, pin_c, pin_d, pin_e;
  int   errors = 0, checks = 0;
  typedef struct { string tag; logic exp; } exp_t;
  exp_t sb[$];
  sb_io_if ia(), ib(), ic(), id(), ie();
  assign pin_a = ea_en ? ea_v : 1'bz;
  assign pin_e = ee_v;
  sb_io #(.PIN_TYPE(6'b101001), .PULLUP(1'b1)) u_a (.clk(clk), .reset(reset), .package_pin(pin_a), .io(ia.slave));
  sb_io #(.PIN_TYPE(6'b010100), .PULLUP(1'b0)) u_b (.clk(clk), .reset(reset), .package_pin(pin_b), .io(ib.slave));
  sb_io #(.PIN_TYPE(6'b010000), .PULLUP(1'b0)) u_c (.clk(clk), .reset(reset), .package_pin(pin_c), .io(ic.slave));
  sb_io #(.PIN_TYPE(6'b110100), .PULLUP(1'b1)) u_d (.clk(clk), .reset(reset), .package_pin(pin_d), .io(id.slave));
  sb_io #(.PIN_TYPE(6'b000011), .PULLUP(1'b0)) u_e (.clk(clk), .reset(reset), .package_pin(pin_e), .io(ie.slave));
  always #5 clk = ~clk;
  task automatic push(input string t, input logic e);
    sb.push_back('{t, e});
  endtask
  task automatic chk(input logic obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%b expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    clk = 0; reset = 0; ea_en = 0; ea_v = 0; ee_v = 0;
    ia.clock_enable = 1; ia.latch_input_value = 0; ia.output_enable = 0; ia.d_out_0 = 0; ia.d_out_1 = 0;
    ib.clock_enable = 1; ib.latch_input_value = 0; ib.output_enable = 0; ib.d_out_0 = 0; ib.d_out_1 = 0;
    ic.clock_enable = 1; ic.latch_input_value = 0; ic.output_enable = 0; ic.d_out_0 = 0; ic.d_out_1 = 0;
    id.clock_enable = 1; id.latch_input_value = 0; id.output_enable = 0; id.d_out_0 = 0; id.d_out_1 = 0;
    ie.clock_enable = 1; ie.latch_input_value = 0; ie.output_enable = 0; ie.d_out_0 = 0; ie.d_out_1 = 0;
    push("rst_b_pin", 0); push("rst_b_din0", 0); push("rst_c_din1", 0);
    push("rst_d_pin_pullup", 1); push("rst_a_din0_pin", 1); push("rst_e_din0", 0);
    #2;
    chk(pin_b); chk(ib.d_in_0); chk(ic.d_in_1); chk(pin_d); chk(ia.d_in_0); chk(ie.d_in_0);
    #1 reset = 1;
    tick();
    ia.output_enable = 1; ia.d_out_0 = 0;
    push("a_pin_drv0", 0); push("a_din0_drv0", 0);
    #1 chk(pin_a); chk(ia.d_in_0);
    ia.output_enable = 0;
    push("a_pin_pullup", 1); push("a_din0_pullup", 1);
    #1 chk(pin_a); chk(ia.d_in_0);
    ea_en = 1; ea_v = 0;
    push("a_din0_ext0", 0);
    #1 chk(ia.d_in_0);
    ea_en = 0; ia.output_enable = 1; ia.d_out_0 = 1;
    push("a_din0_drv1", 1);
    #1 chk(ia.d_in_0);
    ia.output_enable = 0;
    tick();
    ib.d_out_0 = 1;
    push("b_pin_pre", 0);
    #1 chk(pin_b);
    tick();
    push("b_pin_1", 1); push("b_din0_1", 0);
    chk(pin_b); chk(ib.d_in_0);
    ib.d_out_0 = 0;
    tick();
    push("b_pin_2", 0); push("b_din0_2", 1);
    chk(pin_b); chk(ib.d_in_0);
    ib.d_out_0 = 1;
    tick();
    push("b_pin_3", 1); push("b_din0_3", 0);
    chk(pin_b); chk(ib.d_in_0);
    reset = 0;
    push("b_pin_rst", 0); push("b_din0_rst", 0);
    #1 chk(pin_b); chk(ib.d_in_0);
    #1 reset = 1;
    push("b_pin_rel", 1);
    tick();
    chk(pin_b);
    ib.clock_enable = 0; ib.d_out_0 = 0;
    push("b_pin_ce0_a", 1); push("b_pin_ce0_b", 1);
    tick(); chk(pin_b);
    tick(); chk(pin_b);
    ib.clock_enable = 1;
    push("b_pin_ce1_pre", 1); push("b_pin_ce1", 0);
    #1 chk(pin_b);
    tick(); chk(pin_b);
    tick();
    ic.d_out_0 = 1; ic.d_out_1 = 0;
    push("c_pin_hi", 1); push("c_pin_lo", 0);
    tick();
    #1 chk(pin_c);
    #5 chk(pin_c);
    ic.d_out_0 = 0; ic.d_out_1 = 1;
    push("c_pin_hi_sw", 0); push("c_pin_lo_sw", 1);
    #5 chk(pin_c);
    #5 chk(pin_c);
    ic.d_out_0 = 1; ic.d_out_1 = 1;
    push("c_din1", 1); push("c_pin_lo_11", 1);
    #10 chk(ic.d_in_1); chk(pin_c);
    tick();
    id.output_enable = 1; id.d_out_0 = 0;
    push("d_pin_before_edge", 1); push("d_pin_after_edge", 0);
    #3 chk(pin_d);
    tick(); chk(pin_d);
    reset = 0;
    push("d_pin_rst", 1);
    #1 chk(pin_d);
    reset = 1;
    push("d_pin_rel", 0);
    tick(); chk(pin_d);
    id.output_enable = 0;
    push("d_pin_oe0_pre", 0); push("d_pin_oe0", 1);
    #1 chk(pin_d);
    tick(); chk(pin_d);
    ie.latch_input_value = 0; ee_v = 1;
    push("e_din0_open", 1);
    #1 chk(ie.d_in_0);
    ie.latch_input_value = 1;
    #1 ee_v = 0;
    push("e_din0_held", 1);
    #1 chk(ie.d_in_0);
    ie.latch_input_value = 0;
    push("e_din0_release", 0);
    #1 chk(ie.d_in_0);
    @(negedge clk);
    #2 ee_v = 1;
    push("e_din1_cap1", 1); push("e_din1_hold", 1); push("e_din1_cap0", 0);
    @(negedge clk);
    #1 chk(ie.d_in_1);
    ee_v = 0;
    #2 chk(ie.d_in_1);
    @(negedge clk);
    #1 chk(ie.d_in_1);
    if (sb.size() != 0) begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sb_io.md
# sb_io

Single-pin bidirectional I/O cell for the iCE40 fabric, modelling the SB_IO primitive on one clock. It sits between a package pin and core logic (e.g. the I2C master's SDA line) and provides configurable combinational, registered, inverted or DDR output paths, tristate control and optional weak pull-up. PIN_TYPE selects the input and output modes.

## Interface
- PIN_TYPE, 6'b000000, [5:4] output-enable mode, [3:2] output data mode, [1:0] input mode
- PULLUP, 1'b0, 1 = weak pull-up on the pin when no driver is active
- clk  input  1  I/O register clock; posedge and negedge both used (DDR)
- reset  input  1  asynchronous, active-low; clears every internal register to 0
- package_pin  inout  1  pad
- clock_enable  input  1  gates all register updates; 1 = update
- latch_input_value  input  1  1 = hold the input latch (latched input modes)
- output_enable  input  1  core tristate control
- d_out_0  input  1  output data, posedge / SDR
- d_out_1  input  1  output data, negedge half (DDR)
- d_in_0  output  1  input data, posedge / SDR
- d_in_1  output  1  input data captured on negedge

## Operation
- Registers: dout_q0, oe_q and din_q0 on posedge clk; dout_q1 and din_q1 on negedge clk.
  - All load only when clock_enable=1.
  - All clear to 0 asynchronously while reset=0.
- Input mode, PIN_TYPE[1:0]:
  - 01: d_in_0 = package_pin, combinational.
  - 00: d_in_0 = din_q0.
  - 11: d_in_0 = transparent latch of pin; holds while latch_input_value=1.
  - 10: d_in_0 = din_q0, except it holds its value while latch_input_value=1.
  - d_in_1 = din_q1 in every mode.
- Output data, PIN_TYPE[3:2]:
  - 10: dout = d_out_0, combinational.
  - 01: dout = dout_q0.
  - 11: dout = ~dout_q0.
  - 00, DDR: dout = dout_q0 while clk=1, dout_q1 while clk=0.
- Output enable, PIN_TYPE[5:4]:
  - 00: pin never driven.
  - 01: pin always driven with dout.
  - 10: driven when output_enable=1, else Z.
  - 11: driven when oe_q=1, else Z.
- Pull-up:
  - PULLUP=1 and pin undriven: pin resolves to 1. Required model: weak pull, so an external driver overrides it.
  - PULLUP=0 and undriven: pin = Z.
- Reads of package_pin always see the resolved pad value, including the cell's own driven value.

## Timing
- Combinational paths (in 01, out 10, oe 10): zero-cycle.
- Registered SDR output: pin follows d_out_0 one posedge later.
- Registered OE: pin drive/Z follows output_enable one posedge later.
- Registered input: d_in_0 reflects the pin after the next posedge.
- d_in_1 reflects the pin sampled at the most recent negedge.
- DDR: data applied before posedge k appears during the high phase after k. d_out_1 sampled at the following negedge appears during the low phase.
- clock_enable=0: all registers hold; combinational paths unaffected.
- Reset:
  - Asserted mid-operation, registered outputs go to 0 immediately without a clock edge.
  - In mode 11 the pin goes Z (or 1 with PULLUP).
  - Inverted mode drives 1 during reset.
  - Release takes effect at the next active edge.
- Reset values: d_in_0 = 0 in registered/latched modes, pin value in mode 01; d_in_1 = 0.

## Test plan
- PIN_TYPE=6'b101001, PULLUP=1:
  - output_enable=1, d_out_0=0 -> pin=0, d_in_0=0.
  - output_enable=0 -> pin=1 via pull-up, d_in_0=1.
  - External 0 driven while output_enable=0 -> d_in_0=0.
- PIN_TYPE=6'b010100: d_out_0 toggles 1,0,1 on successive cycles -> pin and d_in_0 each follow one posedge later. Pulsing reset=0 mid-stream -> pin=0 immediately.
- PIN_TYPE=6'b010000, DDR: d_out_0=1, d_out_1=0 -> pin is 1 in the high phase, 0 in the low phase. Swapped values -> inverted pattern. d_in_1 captures the low-phase value.
- PIN_TYPE=6'b110100, oe registered: output_enable 0->1 at cycle 3 -> pin leaves Z at posedge 4, not before.
- clock_enable=0 while d_out_0 changes in registered mode -> pin holds. Re-enable -> pin updates on the next posedge.
- PIN_TYPE=6'b000011, latched input: pin 1, latch_input_value=1, then pin 0 -> d_in_0 stays 1. Release -> d_in_0=0.
